// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file with write bypass and pending-write scoreboard
// Two combinational read ports, two write ports (port 1 wins), busy bits tracking issued producers.
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  input  logic              wr0_en,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam logic [ADDR_W:0] NUM_L = NUM_REGS[ADDR_W:0];

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic [ADDR_W:0]     r_busy_cnt;

  logic                w_wr0_ok;
  logic                w_wr1_ok;
  logic                w_iss_ok;
  logic                w_wr0_store;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic                w_inc;
  logic                w_dec0;
  logic                w_dec1;
  logic [ADDR_W:0]     w_cnt_nxt;
  logic [DATA_W:0]     w_rd_a;
  logic [DATA_W:0]     w_rd_b;

  // An address is legal when implemented and not the hardwired zero register.
  function automatic logic f_legal(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < NUM_L) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Returns {busy, data} for one read port, including same-cycle forwarding.
  function automatic logic [DATA_W:0] f_read(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] d;
    logic              b;
    d = '0;
    b = 1'b0;
    if (f_legal(a)) begin
      d = r_regs[a];
      b = r_busy[a];
      if (BYPASS != 0) begin
        if (w_wr1_ok && (wr1_addr == a)) begin
          d = wr1_data;
          b = w_iss_ok && (iss_addr == a);
        end else if (w_wr0_ok && (wr0_addr == a)) begin
          d = wr0_data;
          b = w_iss_ok && (iss_addr == a);
        end
      end
    end
    return {b, d};
  endfunction

  assign w_wr0_ok    = wr0_en && f_legal(wr0_addr);
  assign w_wr1_ok    = wr1_en && f_legal(wr1_addr);
  assign w_iss_ok    = iss_en && f_legal(iss_addr);
  assign w_wr0_store = w_wr0_ok && !(w_wr1_ok && (wr1_addr == wr0_addr));

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr0_ok) w_busy_nxt[wr0_addr] = 1'b0;
    if (w_wr1_ok) w_busy_nxt[wr1_addr] = 1'b0;
    if (w_iss_ok) w_busy_nxt[iss_addr] = 1'b1;
  end

  // Each distinct busy register cleared counts once; an issue to the same address cancels its clear.
  assign w_inc  = w_iss_ok && !r_busy[iss_addr];
  assign w_dec0 = w_wr0_ok && r_busy[wr0_addr]
                  && !(w_iss_ok && (iss_addr == wr0_addr))
                  && !(w_wr1_ok && (wr1_addr == wr0_addr));
  assign w_dec1 = w_wr1_ok && r_busy[wr1_addr]
                  && !(w_iss_ok && (iss_addr == wr1_addr));
  assign w_cnt_nxt = r_busy_cnt + {{ADDR_W{1'b0}}, w_inc}
                     - {{ADDR_W{1'b0}}, w_dec0} - {{ADDR_W{1'b0}}, w_dec1};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      if (w_wr0_store) r_regs[wr0_addr] <= wr0_data;
      if (w_wr1_ok)    r_regs[wr1_addr] <= wr1_data;
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_cnt_nxt;
    end
  end

  assign w_rd_a    = f_read(rd_addr_a);
  assign w_rd_b    = f_read(rd_addr_b);
  assign rd_data_a = w_rd_a[DATA_W-1:0];
  assign rd_busy_a = w_rd_a[DATA_W];
  assign rd_data_b = w_rd_b[DATA_W-1:0];
  assign rd_busy_b = w_rd_b[DATA_W];
  assign busy_cnt  = r_busy_cnt;

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - directed self-checking bench for reg_file_mp
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd_addr_a, rd_addr_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic        rd_busy_a, rd_busy_b;
  logic        wr0_en, wr1_en, iss_en;
  logic [4:0]  wr0_addr, wr1_addr, iss_addr;
  logic [31:0] wr0_data, wr1_data;
  logic [5:0]  busy_cnt;

  int n_asserts = 0;
  int n_fail    = 0;

  reg_file_mp dut (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .rd_busy_a(rd_busy_a), .rd_busy_b(rd_busy_b),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wr0_en = 1'b0; wr1_en = 1'b0; iss_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rd_addr_a = 5'd0; rd_addr_b = 5'd0;
    wr0_addr = 5'd0; wr1_addr = 5'd0; iss_addr = 5'd0;
    wr0_data = 32'd0; wr1_data = 32'd0;
    idle();
    tick();
    tick();
    rst = 1'b0;
    rd_addr_a = 5'd5; rd_addr_b = 5'd7;
    #1;
    check("reset_data_a", rd_data_a, 32'h0);
    check("reset_busy_a", rd_busy_a, 32'h0);
    check("reset_cnt", busy_cnt, 32'h0);

    // 1: simple write then read
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
    tick();
    idle();
    #1;
    check("wr_rd_data", rd_data_a, 32'hDEADBEEF);
    check("wr_rd_busy", rd_busy_a, 32'h0);

    // 2: dual write same address, port 1 wins, forwarded on B
    wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h11111111;
    wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h22222222;
    rd_addr_b = 5'd7;
    #1;
    check("bypass_prio", rd_data_b, 32'h22222222);
    tick();
    idle();
    #1;
    check("dual_wr_stored", rd_data_b, 32'h22222222);

    // 3: zero register ignores writes and issues
    wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFFFFFFFF;
    iss_en = 1'b1; iss_addr = 5'd0;
    rd_addr_a = 5'd0;
    #1;
    check("zero_fwd_data", rd_data_a, 32'h0);
    check("zero_fwd_busy", rd_busy_a, 32'h0);
    tick();
    idle();
    #1;
    check("zero_data", rd_data_a, 32'h0);
    check("zero_busy", rd_busy_a, 32'h0);
    check("zero_cnt", busy_cnt, 32'h0);

    // 4: two issues, then two writes clearing both in one cycle
    iss_en = 1'b1; iss_addr = 5'd3;
    tick();
    iss_addr = 5'd9;
    tick();
    idle();
    rd_addr_a = 5'd3; rd_addr_b = 5'd9;
    #1;
    check("iss_cnt2", busy_cnt, 32'd2);
    check("iss_busy3", rd_busy_a, 32'h1);
    check("iss_busy9", rd_busy_b, 32'h1);
    wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h00000033;
    wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h00000099;
    #1;
    check("fwd_data3", rd_data_a, 32'h00000033);
    check("fwd_busy3", rd_busy_a, 32'h0);
    check("fwd_data9", rd_data_b, 32'h00000099);
    tick();
    idle();
    #1;
    check("clr_cnt0", busy_cnt, 32'd0);
    check("clr_busy3", rd_busy_a, 32'h0);
    check("clr_busy9", rd_busy_b, 32'h0);
    check("clr_data9", rd_data_b, 32'h00000099);

    // 5: issue and write same address, set wins
    iss_en = 1'b1; iss_addr = 5'd4;
    wr0_en = 1'b1; wr0_addr = 5'd4; wr0_data = 32'h00000044;
    rd_addr_a = 5'd4;
    #1;
    check("iss_wr_fwd_data", rd_data_a, 32'h00000044);
    check("iss_wr_fwd_busy", rd_busy_a, 32'h1);
    tick();
    idle();
    #1;
    check("iss_wr_busy", rd_busy_a, 32'h1);
    check("iss_wr_cnt", busy_cnt, 32'd1);
    check("iss_wr_data", rd_data_a, 32'h00000044);

    // re-issue busy register and clear a non-busy one: count unchanged
    iss_en = 1'b1; iss_addr = 5'd4;
    wr0_en = 1'b1; wr0_addr = 5'd10; wr0_data = 32'h0000000A;
    tick();
    idle();
    #1;
    check("no_underflow_cnt", busy_cnt, 32'd1);
    iss_en = 1'b1; iss_addr = 5'd6;
    tick();
    idle();
    #1;
    check("pre_rst_cnt", busy_cnt, 32'd2);

    // 6: reset overrides a simultaneous write
    rst = 1'b1;
    wr1_en = 1'b1; wr1_addr = 5'd2; wr1_data = 32'h0000ABCD;
    tick();
    rst = 1'b0;
    idle();
    rd_addr_a = 5'd5; rd_addr_b = 5'd2;
    #1;
    check("rst_data5", rd_data_a, 32'h0);
    check("rst_data2", rd_data_b, 32'h0);
    check("rst_cnt", busy_cnt, 32'd0);
    rd_addr_a = 5'd4; rd_addr_b = 5'd6;
    #1;
    check("rst_busy4", rd_busy_a, 32'h0);
    check("rst_busy6", rd_busy_b, 32'h0);
    check("rst_data4", rd_data_a, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Clocked, parametrised multi-port register file for the CPU datapath; successor to the combinational, delay-modelled single-write register array.
- Two combinational read ports and two synchronous write ports (ALU writeback, load writeback).
- Optional hardwired zero register and optional write-to-read bypass.
- Per-register pending-write scoreboard, so decode can stall on RAW hazards.

Parameters:
DATA_W, 32, register data width in bits
ADDR_W, 5, register address width
NUM_REGS, 32, implemented registers (1..2^ADDR_W); addresses >= NUM_REGS are unimplemented
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never busy
BYPASS, 1, 1 = same-cycle write data/busy-clear forwarded to read ports

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
rd_addr_a  in  ADDR_W  read port A address
rd_addr_b  in  ADDR_W  read port B address
rd_data_a  out  DATA_W  read port A data
rd_data_b  out  DATA_W  read port B data
rd_busy_a  out  1  pending write outstanding on rd_addr_a
rd_busy_b  out  1  pending write outstanding on rd_addr_b
wr0_en  in  1  write port 0 enable (ALU writeback)
wr0_addr  in  ADDR_W  write port 0 address
wr0_data  in  DATA_W  write port 0 data
wr1_en  in  1  write port 1 enable (load writeback), priority over port 0
wr1_addr  in  ADDR_W  write port 1 address
wr1_data  in  DATA_W  write port 1 data
iss_en  in  1  instruction issued that will write iss_addr
iss_addr  in  ADDR_W  destination being marked pending
busy_cnt  out  ADDR_W+1  number of registers currently marked busy

Behaviour:
- Reset: rst high at a rising edge clears all registers to 0, all busy bits to 0 and busy_cnt to 0. rst overrides any write or issue in the same cycle. Reset mid-operation discards all pending state with no partial writes.
- Reads are combinational from registered state, zero latency.
  - Address >= NUM_REGS: read returns 0 and busy 0.
  - ZERO_REG=1 and address 0: returns 0 and busy 0.
- Writes:
  - wrN_en high: register[wrN_addr] <= wrN_data at the rising edge.
  - Writes to unimplemented addresses are ignored.
  - Writes to address 0 are ignored when ZERO_REG=1.
  - Both ports writing the same address in the same cycle: port 1 data is stored.
- Bypass (BYPASS=1):
  - If a read address matches an enabled, legal write address in the same cycle, rd_data returns that write data (port 1 over port 0).
  - Forwarded reads also report busy 0, unless a same-cycle iss_en targets the same address.
- BYPASS=0: reads return the pre-edge value and the pre-edge busy bit.
- Scoreboard:
  - iss_en sets busy[iss_addr] at the edge.
  - Any enabled legal write clears busy[wr addr] at the edge.
  - Issue and write to the same address in the same cycle: the set wins (newer producer).
  - Issuing to an already-busy register leaves it busy; no count change.
  - Issue to address 0 (ZERO_REG=1) or an unimplemented address is ignored.
- busy_cnt is a register equal to the popcount of the busy vector after each edge. It is updated incrementally by +1 per new set and -1 per cleared bit, including the case where two ports clear two different registers in one cycle. It never underflows: clearing a non-busy register does not decrement.
- No X propagation: all outputs are defined from the first reset onward.

Test Plan:
1. Reset, then write wr0 addr 5 = 0xDEADBEEF. Next cycle, read A addr 5 returns 0xDEADBEEF and busy_a is 0.
2. wr0 and wr1 both write addr 7 (0x11111111 / 0x22222222) with read B = 7 in the same cycle. Returns 0x22222222 combinationally (BYPASS=1); after the edge, 7 holds 0x22222222.
3. ZERO_REG=1: write addr 0 = 0xFFFFFFFF and iss_en addr 0. Read addr 0 returns 0, busy 0, busy_cnt stays 0.
4. iss addr 3, then iss addr 9: busy_cnt = 2 and rd_busy on 3 is 1. Then wr0 addr 3 plus wr1 addr 9 in one cycle: busy_cnt = 0 and both busy bits are 0.
5. iss addr 4 together with wr0 addr 4 in the same cycle: busy[4] = 1 after the edge and busy_cnt increments by 1. Data 4 updated.
6. With registers written and busy set, assert rst together with wr1 addr 2 = 0xABCD. Next cycle all reads return 0, all busy 0, busy_cnt 0.
